// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default geometry and the strobe-derived op-code.
package stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_TOS  = 3'd3,
    OP_REPL = 3'd4
  } op_e;

  // push+pop dominates as a replace; tos alongside push is handled by the caller.
  function automatic op_e decode_op(input logic push, input logic pop, input logic tos);
    op_e op;
    if (push && pop) begin
      op = OP_REPL;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end else if (tos) begin
      op = OP_TOS;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module stack_ram
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port; contents need no reset since the pointer gates every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack: pointer, sticky error flags and registered read data around stack_ram.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic [DATA_W-1:0] din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              ovf_new_s, unf_new_s;
  logic              empty_s, full_s, we_s;
  logic [AW-1:0]     waddr_s, top_addr_s;
  logic [DATA_W-1:0] top_s;
  op_e               op_s;

  assign empty_s    = (count_q == {CNT_W{1'b0}});
  assign full_s     = (count_q == CNT_FULL);
  assign top_addr_s = AW'(count_q - CNT_ONE);
  assign op_s       = decode_op(push, pop, tos);

  stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (din),
    .raddr (top_addr_s),
    .rdata (top_s)
  );

  // Next-state decode of pointer, read data, RAM write and new error events.
  always_comb begin
    count_d   = count_q;
    dout_d    = dout_q;
    we_s      = 1'b0;
    waddr_s   = count_q[AW-1:0];
    ovf_new_s = 1'b0;
    unf_new_s = 1'b0;
    case (op_s)
      OP_REPL: begin
        if (empty_s) begin
          we_s      = 1'b1;
          waddr_s   = {AW{1'b0}};
          count_d   = CNT_ONE;
          unf_new_s = 1'b1;
        end else begin
          we_s    = 1'b1;
          waddr_s = top_addr_s;
          dout_d  = top_s;
        end
      end
      OP_PUSH: begin
        if (full_s) begin
          ovf_new_s = 1'b1;
        end else begin
          we_s    = 1'b1;
          count_d = count_q + CNT_ONE;
        end
        // tos rides along with push and reports the pre-push top.
        if (tos && empty_s) begin
          unf_new_s = 1'b1;
        end else if (tos) begin
          dout_d = top_s;
        end else begin
          dout_d = dout_q;
        end
      end
      OP_POP: begin
        if (empty_s) begin
          unf_new_s = 1'b1;
        end else begin
          dout_d  = top_s;
          count_d = count_q - CNT_ONE;
        end
      end
      OP_TOS: begin
        if (empty_s) begin
          unf_new_s = 1'b1;
        end else begin
          dout_d = top_s;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    ovf_d = ovf_new_s | (ovf_q & ~err_clr);
    unf_d = unf_new_s | (unf_q & ~err_clr);
  end

  // State registers with synchronous reset overriding all strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      dout_q  <= {DATA_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;
  assign empty = empty_s;
  assign full  = full_s;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based stack model predicts every cycle's outputs.
module tb_stack_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
  logic [DATA_W-1:0] din = 8'h00;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  count;
  logic              empty, full, ovf, unf;

  always #5 clk = ~clk;

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
    .err_clr(err_clr), .dout(dout), .count(count), .empty(empty),
    .full(full), .ovf(ovf), .unf(unf)
  );

  typedef struct {
    int dout; int count; int empty; int full; int ovf; int unf;
  } exp_t;

  exp_t sb_q[$];
  int   stk[$];
  int   m_dout = 0, m_ovf = 0, m_unf = 0;
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one cycle of stimulus and queue the state the stack must show after the edge.
  task automatic drive(input bit r, input bit pu, input bit po, input bit t,
                       input int d, input bit ec);
    int   nov, nun;
    exp_t e;
    @(negedge clk);
    rst = r; push = pu; pop = po; tos = t; din = d[7:0]; err_clr = ec;
    if (r) begin
      stk.delete();
      m_dout = 0; m_ovf = 0; m_unf = 0;
    end else begin
      nov = 0; nun = 0;
      if (pu && po) begin
        if (stk.size() == 0) begin
          stk.push_back(d & 255); nun = 1;
        end else begin
          m_dout = stk[$];
          stk[stk.size()-1] = d & 255;
        end
      end else if (pu) begin
        if (t && stk.size() == 0) nun = 1;
        else if (t) m_dout = stk[$];
        if (stk.size() == DEPTH) nov = 1;
        else stk.push_back(d & 255);
      end else if (po) begin
        if (stk.size() == 0) nun = 1;
        else m_dout = stk.pop_back();
      end else if (t) begin
        if (stk.size() == 0) nun = 1;
        else m_dout = stk[$];
      end
      m_ovf = (nov != 0 || (m_ovf != 0 && !ec)) ? 1 : 0;
      m_unf = (nun != 0 || (m_unf != 0 && !ec)) ? 1 : 0;
    end
    e.dout  = m_dout;
    e.count = stk.size();
    e.empty = (stk.size() == 0) ? 1 : 0;
    e.full  = (stk.size() == DEPTH) ? 1 : 0;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: every edge the DUT presents a new state; compare it with the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("dout",  {24'h0, dout},  e.dout);
      chk("count", {27'h0, count}, e.count);
      chk("empty", {31'h0, empty}, e.empty);
      chk("full",  {31'h0, full},  e.full);
      chk("ovf",   {31'h0, ovf},   e.ovf);
      chk("unf",   {31'h0, unf},   e.unf);
    end
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Reset mid-activity, including with strobes asserted.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h66, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);

    // LIFO order.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle();

    // Fill, overflow, tos on full, clear.
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, i, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Drain, then underflow via pop and tos on empty.
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

    // Replace.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // err_clr colliding with a new underflow, then err_clr alone.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle();

    // Randomized phases alternating push-heavy and pop-heavy traffic.
    for (int i = 0; i < 1500; i++) begin
      int  bias;
      bit  r, pu, po, t, ec;
      bias = ((i / 100) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(199, 0) == 0);
      pu = ($urandom_range(99, 0) < bias);
      po = ($urandom_range(99, 0) < (100 - bias));
      t  = ($urandom_range(3, 0) == 0);
      ec = ($urandom_range(15, 0) == 0);
      drive(r, pu, po, t, $urandom_range(255, 0), ec);
    end
    idle();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
